hazard_ctrl: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage RISC-V core with I/D caches. It generates per-stage stall and flush controls from these sources:
- load-use dependencies;
- branch/jump redirects resolved in EX;
- multi-cycle instruction-cache and data-cache miss handshakes.

It sits beside the forwarding unit, which covers all other RAW cases. It also keeps stall and flush performance counters.

---
 rtl/hazard_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard sequencer interface: pipeline-side hazard inputs and stall/flush/replay controls.
// The master modport is the pipeline side and the slave modport is the hazard controller.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic             rs1_useD;
  logic             rs2_useD;
  logic [4:0]       rdE;
  logic             memreadE;
  logic             redirectE;
  logic             icache_miss;
  logic             icache_ready;
  logic             dcache_reqM;
  logic             dcache_ready;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             stallM;
  logic             flushD;
  logic             flushE;
  logic             flushW;
  logic             replayF;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output rs1D, rs2D, rs1_useD, rs2_useD, rdE, memreadE, redirectE,
           icache_miss, icache_ready, dcache_reqM, dcache_ready,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW, replayF,
           stall_cycles, flush_count
  );

  modport slave (
    input  rs1D, rs2D, rs1_useD, rs2_useD, rdE, memreadE, redirectE,
           icache_miss, icache_ready, dcache_reqM, dcache_ready,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW, replayF,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: D-miss > redirect > load-use > I-miss.
// state | meaning
// RUN   | no outstanding cache miss
// DWAIT | data-cache miss outstanding, whole pipe frozen, WB bubbled
// IWAIT | instruction-cache miss outstanding, fetch held
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             redir_pend_q, redir_pend_d;
  logic             ichit_q, ichit_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic dmiss, imiss, iresolve, load_use, lu_stall, replay, any_stall;

  // ichit_q remembers an icache_ready that arrived while the pipe was frozen by a D-miss
  always_comb begin
    dmiss    = hz.dcache_reqM & ~hz.dcache_ready;
    imiss    = hz.icache_miss & ~hz.icache_ready & ~ichit_q;
    iresolve = (hz.icache_miss & hz.icache_ready) | ichit_q;
    load_use = hz.memreadE & (hz.rdE != 5'd0) &
               ((hz.rs1_useD & (hz.rdE == hz.rs1D)) |
                (hz.rs2_useD & (hz.rdE == hz.rs2D)));
  end

  always_comb begin
    state_d      = state_q;
    redir_pend_d = redir_pend_q;
    ichit_d      = ichit_q;
    lu_stall     = 1'b0;
    replay       = 1'b0;
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b0;
    hz.flushW    = 1'b0;
    hz.replayF   = 1'b0;
    flush_cnt_d  = flush_cnt_q;
    if (!rst) begin
      if (dmiss) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
        hz.flushW = 1'b1;
        ichit_d   = ichit_q | (hz.icache_miss & hz.icache_ready);
        state_d   = DWAIT;
      end else begin
        lu_stall     = load_use & ~hz.redirectE;
        replay       = redir_pend_q & iresolve;
        hz.stallF    = imiss | lu_stall;
        hz.stallD    = lu_stall;
        hz.flushE    = hz.redirectE | lu_stall;
        hz.flushD    = hz.redirectE | replay | (imiss & ~lu_stall);
        hz.replayF   = replay;
        ichit_d      = 1'b0;
        redir_pend_d = (redir_pend_q & ~replay) | (hz.redirectE & imiss);
        if (hz.redirectE) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
        case (state_q)
          RUN:     if (imiss) state_d = IWAIT;
          DWAIT:   state_d = RUN;
          IWAIT:   if (iresolve || !hz.icache_miss) state_d = RUN;
          default: state_d = RUN;
        endcase
      end
    end
  end

  always_comb begin
    any_stall   = hz.stallF | hz.stallD | hz.stallE | hz.stallM;
    stall_cnt_d = any_stall ? stall_cnt_q + 1'b1 : stall_cnt_q;
    // counters read as zero during the reset cycle itself
    hz.stall_cycles = rst ? '0 : stall_cnt_q;
    hz.flush_count  = rst ? '0 : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      redir_pend_q <= 1'b0;
      ichit_q      <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      ichit_q      <= ichit_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan sequences plus randomized traffic
// checked against a priority-rule reference model.
module tb_hazard_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_if #(.CNT_W(CNT_W)) hz();
  hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(hz));

  typedef struct packed {
    logic [7:0]  ctl;  // {stallF,stallD,stallE,stallM,flushD,flushE,flushW,replayF}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  typedef struct {
    bit rst, reqM, dready, im, ir, redir, memrd, u1, u2;
    logic [4:0] rd, r1, r2;
  } stim_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit          m_pend, m_ichit;
  int unsigned m_sc, m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Reference model: apply the priority rules to this cycle's inputs, then advance model state
  task automatic step(input stim_t s);
    exp_t e;
    bit dm, imv, ires, lu, lus, rp, sF, sD, sE, sM, fD, fE, fW;
    rst             = s.rst;
    hz.dcache_reqM  = s.reqM;
    hz.dcache_ready = s.dready;
    hz.icache_miss  = s.im;
    hz.icache_ready = s.ir;
    hz.redirectE    = s.redir;
    hz.memreadE     = s.memrd;
    hz.rdE          = s.rd;
    hz.rs1D         = s.r1;
    hz.rs2D         = s.r2;
    hz.rs1_useD     = s.u1;
    hz.rs2_useD     = s.u2;
    e = '0;
    if (s.rst) begin
      m_pend = 0; m_ichit = 0; m_sc = 0; m_fc = 0;
    end else begin
      e.sc = m_sc;
      e.fc = m_fc;
      dm   = s.reqM && !s.dready;
      imv  = s.im && !s.ir && !m_ichit;
      ires = (s.im && s.ir) || m_ichit;
      lu   = s.memrd && s.rd != 0 && ((s.u1 && s.rd == s.r1) || (s.u2 && s.rd == s.r2));
      {sF, sD, sE, sM, fD, fE, fW, rp} = '0;
      if (dm) begin
        {sF, sD, sE, sM, fW} = '1;
        if (s.im && s.ir) m_ichit = 1;
      end else begin
        lus = lu && !s.redir;
        rp  = m_pend && ires;
        sF  = lus || imv;
        sD  = lus;
        fE  = s.redir || lus;
        fD  = s.redir || rp || (imv && !lus);
        m_pend  = (m_pend && !rp) || (s.redir && imv);
        m_ichit = 0;
        if (s.redir) m_fc++;
      end
      if (sF || sD || sE || sM) m_sc++;
      e.ctl = {sF, sD, sE, sM, fD, fE, fW, rp};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("ctl", {hz.stallF, hz.stallD, hz.stallE, hz.stallM,
                  hz.flushD, hz.flushE, hz.flushW, hz.replayF}, mon_e.ctl);
      chk("stall_cycles", hz.stall_cycles, mon_e.sc);
      chk("flush_count", hz.flush_count, mon_e.fc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    stim_t s;
    bit i_act, d_act;
    int i_left, d_left;
    i_act = 0; d_act = 0; i_left = 0; d_left = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    s = idle(); s.rst = 1; step(s); step(s);

    // load-use on rs1, then rdE=x0 does not stall
    s = idle(); s.memrd = 1; s.rd = 5; s.r1 = 5; s.u1 = 1; step(s);
    s = idle(); step(s);
    s = idle(); s.memrd = 1; s.rd = 0; s.r1 = 0; s.u1 = 1; step(s);
    s = idle(); s.memrd = 1; s.rd = 7; s.r2 = 7; s.u2 = 1; s.r1 = 3; s.u1 = 1; step(s);

    // D-miss of 4 cycles
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.reqM = 1;
    repeat (4) step(s);
    s.dready = 1; step(s);
    chk("dmiss_stall_cycles", hz.stall_cycles, 32'd4);
    s = idle(); step(s);

    // redirect during I-miss, replay on icache_ready
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.im = 1; step(s);
    s.redir = 1; step(s);
    s.redir = 0; step(s);
    s.ir = 1; step(s);
    s = idle(); step(s);
    chk("redir_flush_count", hz.flush_count, 32'd1);

    // priority: dmiss + redirect + load-use together
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.reqM = 1; s.redir = 1; s.memrd = 1; s.rd = 5; s.r1 = 5; s.u1 = 1;
    step(s); step(s);
    s.dready = 1; step(s);
    s = idle(); step(s);

    // I-miss resolved while frozen by D-miss, with a pending redirect
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.im = 1; s.redir = 1; step(s);
    s = idle(); s.im = 1; s.reqM = 1; step(s);
    s.ir = 1; step(s);
    s = idle(); s.reqM = 1; step(s);
    s.dready = 1; step(s);
    s = idle(); step(s);

    // reset mid-DWAIT, then stale dcache_ready
    s = idle(); s.reqM = 1; step(s); step(s);
    s.rst = 1; step(s);
    s = idle(); s.dready = 1; step(s);
    s = idle(); s.ir = 1; step(s);

    for (int n = 0; n < 2000; n++) begin
      s = idle();
      if (!i_act && $urandom_range(0, 5) == 0) begin i_act = 1; i_left = $urandom_range(0, 4); end
      if (!d_act && $urandom_range(0, 4) == 0) begin d_act = 1; d_left = $urandom_range(0, 3); end
      s.im     = i_act;
      s.ir     = i_act ? (i_left == 0) : ($urandom_range(0, 15) == 0);
      s.reqM   = d_act;
      s.dready = d_act ? (d_left == 0) : ($urandom_range(0, 15) == 0);
      s.redir  = !s.ir && ($urandom_range(0, 4) == 0);
      s.memrd  = $urandom_range(0, 1);
      s.rd     = 5'($urandom_range(0, 3));
      s.r1     = 5'($urandom_range(0, 3));
      s.r2     = 5'($urandom_range(0, 3));
      s.u1     = $urandom_range(0, 1);
      s.u2     = $urandom_range(0, 1);
      s.rst    = ($urandom_range(0, 199) == 0);
      step(s);
      if (i_act) begin if (i_left == 0) i_act = 0; else i_left--; end
      if (d_act) begin if (d_left == 0) d_act = 0; else d_left--; end
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
